// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous memory between the fetch port (I) and
// the load/store port (D). One access in flight at a time; a new grant may
// overlap the response cycle of the previous access.
// Optional feature: define MEM_ARBITER_ROUND_ROBIN_EN for alternating priority
// on contended grants (default build: fixed D-over-I priority).
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    output logic                    i_gnt,
    output logic                    i_rvalid,
    output logic [DATA_WIDTH-1:0]   i_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [DATA_WIDTH/8-1:0] d_be,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    output logic                    d_gnt,
    output logic                    d_rvalid,
    output logic [DATA_WIDTH-1:0]   d_rdata,
    output logic                    m_req,
    output logic                    m_we,
    output logic [DATA_WIDTH/8-1:0] m_be,
    output logic [ADDR_WIDTH-1:0]   m_addr,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    input  logic [DATA_WIDTH-1:0]   m_rdata
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned CNT_W = 3;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             owner_q, owner_d;
    logic             we_q, we_d;       // in-flight access is a store
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
    logic             last_q, last_d;   // winner of the most recent grant
`endif

    logic resp;
    logic free;
    logic win_d;
    logic grant;

    // Response slot, free slot and winner selection
    always_comb begin
        resp  = !rst && (state_q == BUSY) && (cnt_q == CNT_W'(1));
        free  = !rst && ((state_q == IDLE) || resp);
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        win_d = d_req && (!i_req || (last_q == OWN_I));
`else
        win_d = d_req;
`endif
        grant = free && (i_req || d_req);
    end

    // Grant, memory command and response routing
    always_comb begin
        i_gnt    = 1'b0;
        d_gnt    = 1'b0;
        m_req    = 1'b0;
        m_we     = 1'b0;
        m_be     = '0;
        m_addr   = '0;
        m_wdata  = '0;
        i_rvalid = 1'b0;
        d_rvalid = 1'b0;
        i_rdata  = '0;
        d_rdata  = '0;
        if (grant) begin
            m_req = 1'b1;
            if (win_d) begin
                d_gnt   = 1'b1;
                m_we    = d_we;
                m_be    = d_be;
                m_addr  = d_addr;
                m_wdata = d_wdata;
            end else begin
                i_gnt   = 1'b1;
                m_be    = {BE_W{1'b1}};
                m_addr  = i_addr;
            end
        end
        if (resp) begin
            if (owner_q == OWN_D) begin
                d_rvalid = 1'b1;
                d_rdata  = we_q ? '0 : m_rdata;
            end else begin
                i_rvalid = 1'b1;
                i_rdata  = m_rdata;
            end
        end
    end

    // Next-state: latency countdown and ownership capture on grant
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        we_d    = we_q;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        if (state_q == BUSY) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                state_d = IDLE;
            end
        end
        if (grant) begin
            state_d = BUSY;
            cnt_d   = CNT_W'(MEM_LATENCY);
            owner_d = win_d ? OWN_D : OWN_I;
            we_d    = win_d && d_we;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_d  = win_d ? OWN_D : OWN_I;
`endif
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            owner_q <= OWN_I;
            we_q    <= 1'b0;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_q  <= OWN_I;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            we_q    <= we_d;
`ifdef MEM_ARBITER_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

endmodule
